// File: rtl/burst_write_pkg.sv
// rtl/burst_write_pkg.sv - shared state encoding and width helpers for the burst write master
package burst_write_pkg;

  localparam int unsigned BYTE_BITS = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    BURST     = 2'd2
  } state_t;

  // Burstcount must be able to hold MAX_BURST itself, hence the extra bit.
  function automatic int unsigned burst_width(input int unsigned max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/burst_write_fifo.sv
// rtl/burst_write_fifo.sv - single-clock show-ahead FIFO feeding the burst write master
module burst_write_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [PTR_W:0]        used_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr_q;
  logic [PTR_W:0]        rd_ptr_q;
  logic                  push_ok;
  logic                  pop_ok;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign used_o  = wr_ptr_q - rd_ptr_q;
  assign full_o  = (used_o == (PTR_W + 1)'(FIFO_DEPTH));
  assign empty_o = (used_o == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (PTR_W + 1)'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + (PTR_W + 1)'(1);
    end
  end

endmodule

// File: rtl/burst_write_master.sv
// rtl/burst_write_master.sv - Avalon-MM burst write master that splits a command into FIFO-backed bursts
module burst_write_master
  import burst_write_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH          = 32,
  parameter int unsigned DATA_WIDTH             = 32,
  parameter int unsigned BYTE_ENABLE_WIDTH      = DATA_WIDTH / BYTE_BITS,
  parameter int unsigned BYTE_ENABLE_WIDTH_LOG2 = $clog2(BYTE_ENABLE_WIDTH),
  parameter int unsigned LENGTH_WIDTH           = 16,
  parameter int unsigned MAX_BURST              = 8,
  parameter int unsigned BURST_WIDTH            = burst_width(MAX_BURST),
  parameter int unsigned FIFO_DEPTH             = 16,
  parameter int unsigned FIFO_DEPTH_LOG2        = $clog2(FIFO_DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  output logic [ADDRESS_WIDTH-1:0]     master_address,
  output logic                         master_write,
  output logic [DATA_WIDTH-1:0]        master_writedata,
  output logic [BURST_WIDTH-1:0]       master_burstcount,
  output logic [BYTE_ENABLE_WIDTH-1:0] master_byteenable,
  input  logic                         master_waitrequest,
  input  logic                         ctrl_start,
  input  logic [ADDRESS_WIDTH-1:0]     ctrl_baseaddress,
  input  logic [LENGTH_WIDTH-1:0]      ctrl_length,
  output logic                         ctrl_busy,
  output logic                         ctrl_done,
  input  logic                         user_write,
  input  logic [DATA_WIDTH-1:0]        user_writedata,
  output logic                         user_full,
  output logic [FIFO_DEPTH_LOG2:0]     user_used
);

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0] maddr_q, maddr_d;
  logic [LENGTH_WIDTH-1:0]  remaining_q, remaining_d;
  logic [BURST_WIDTH-1:0]   bcount_q, bcount_d;
  logic [BURST_WIDTH-1:0]   beat_q, beat_d;
  logic                     write_q, write_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [LENGTH_WIDTH-1:0]  beats_len;
  logic [BURST_WIDTH-1:0]   beats;
  logic                     fifo_empty;
  logic                     beat_accept;
  logic                     last_beat;

  assign beats_len   = (remaining_q < LENGTH_WIDTH'(MAX_BURST)) ? remaining_q : LENGTH_WIDTH'(MAX_BURST);
  assign beats       = BURST_WIDTH'(beats_len);
  assign beat_accept = write_q && !master_waitrequest && !fifo_empty;
  assign last_beat   = beat_accept && (beat_q == bcount_q - BURST_WIDTH'(1));

  burst_write_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (user_write),
    .data_i  (user_writedata),
    .pop_i   (beat_accept),
    .data_o  (master_writedata),
    .used_o  (user_used),
    .full_o  (user_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    maddr_d     = maddr_q;
    remaining_d = remaining_q;
    bcount_d    = bcount_q;
    beat_d      = beat_q;
    write_d     = write_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_start) begin
          if (ctrl_length != '0) begin
            addr_d      = ctrl_baseaddress;
            remaining_d = ctrl_length;
            busy_d      = 1'b1;
            state_d     = WAIT_DATA;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      // Only launch once every beat is queued so write never drops mid-burst.
      WAIT_DATA: begin
        if (32'(user_used) >= 32'(beats)) begin
          maddr_d  = addr_q;
          bcount_d = beats;
          beat_d   = '0;
          write_d  = 1'b1;
          state_d  = BURST;
        end
      end
      BURST: begin
        if (last_beat) begin
          write_d     = 1'b0;
          addr_d      = addr_q + (ADDRESS_WIDTH'(bcount_q) << BYTE_ENABLE_WIDTH_LOG2);
          remaining_d = remaining_q - LENGTH_WIDTH'(bcount_q);
          if (remaining_q == LENGTH_WIDTH'(bcount_q)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_DATA;
          end
        end else if (beat_accept) begin
          beat_d = beat_q + BURST_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      maddr_q     <= '0;
      remaining_q <= '0;
      bcount_q    <= '0;
      beat_q      <= '0;
      write_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      maddr_q     <= maddr_d;
      remaining_q <= remaining_d;
      bcount_q    <= bcount_d;
      beat_q      <= beat_d;
      write_q     <= write_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign master_address    = maddr_q;
  assign master_write      = write_q;
  assign master_burstcount = bcount_q;
  assign master_byteenable = '1;
  assign ctrl_busy         = busy_q;
  assign ctrl_done         = done_q;

endmodule

// File: tb/tb_burst_write_master.sv
// tb/tb_burst_write_master.sv - directed vector bench for burst_write_master
module tb_burst_write_master;

  localparam int MAXB  = 8;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] master_address;
  logic        master_write;
  logic [31:0] master_writedata;
  logic [3:0]  master_burstcount;
  logic [3:0]  master_byteenable;
  logic        master_waitrequest;
  logic        ctrl_start;
  logic [31:0] ctrl_baseaddress;
  logic [15:0] ctrl_length;
  logic        ctrl_busy;
  logic        ctrl_done;
  logic        user_write;
  logic [31:0] user_writedata;
  logic        user_full;
  logic [4:0]  user_used;

  burst_write_master dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .master_address     (master_address),
    .master_write       (master_write),
    .master_writedata   (master_writedata),
    .master_burstcount  (master_burstcount),
    .master_byteenable  (master_byteenable),
    .master_waitrequest (master_waitrequest),
    .ctrl_start         (ctrl_start),
    .ctrl_baseaddress   (ctrl_baseaddress),
    .ctrl_length        (ctrl_length),
    .ctrl_busy          (ctrl_busy),
    .ctrl_done          (ctrl_done),
    .user_write         (user_write),
    .user_writedata     (user_writedata),
    .user_full          (user_full),
    .user_used          (user_used)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      base;
    int               len;
    int               pre;
    int               feed;
    int               gap;
    bit               stall;
    int               nb;
    logic [3:0][7:0]  bc;
    logic [3:0][31:0] ad;
    int               left;
  } vec_t;

  vec_t        vecs [8];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] q [$];
  logic [31:0] word_ctr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int min_b(input int r);
    return (r < MAXB) ? r : MAXB;
  endfunction

  function automatic vec_t mk(input logic [31:0] base, input int len, input int pre, input int feed,
                              input int gap, input bit stall, input int nb,
                              input int b0, input int b1, input int b2,
                              input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                              input int left);
    vec_t v;
    v.base = base; v.len = len; v.pre = pre; v.feed = feed; v.gap = gap;
    v.stall = stall; v.nb = nb; v.left = left;
    v.bc = '0; v.ad = '0;
    v.bc[0] = 8'(b0); v.bc[1] = 8'(b1); v.bc[2] = 8'(b2);
    v.ad[0] = a0;     v.ad[1] = a1;     v.ad[2] = a2;
    return v;
  endfunction

  task automatic preload(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      user_write = 1'b1;
      user_writedata = word_ctr;
      q.push_back(word_ctr);
      word_ctr++;
    end
    @(negedge clk);
    user_write = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int rem, bidx, beats_done, gap_cnt, feed_left, bursts, prev_used, cur_used, nb;
    bit prev_write, prev_busy, prev_final, finished, acc, exp_w, init_ready, prev_mw;
    preload(v.pre);
    @(negedge clk);
    init_ready = (q.size() >= min_b(v.len));
    ctrl_baseaddress = v.base;
    ctrl_length = 16'(v.len);
    ctrl_start = 1'b1;
    rem = v.len; bidx = 0; beats_done = 0; gap_cnt = 0; feed_left = v.feed; bursts = 0;
    prev_write = 0; prev_busy = 0; prev_final = 0; prev_used = q.size(); finished = 0; prev_mw = 0;
    for (int cyc = 1; cyc <= 600 && !finished; cyc++) begin
      @(negedge clk);
      ctrl_start = 1'b0;
      cur_used = q.size();
      exp_w = prev_write ? !prev_final : (prev_busy && prev_used >= min_b(rem));
      chk($sformatf("v%0d write c%0d", idx, cyc), 32'(master_write), 32'(exp_w));
      chk($sformatf("v%0d busy c%0d", idx, cyc), 32'(ctrl_busy), 32'(rem > 0));
      chk($sformatf("v%0d done c%0d", idx, cyc), 32'(ctrl_done), 32'(prev_final && rem == 0));
      chk($sformatf("v%0d used c%0d", idx, cyc), 32'(user_used), 32'(cur_used));
      chk($sformatf("v%0d full c%0d", idx, cyc), 32'(user_full), 32'(cur_used == DEPTH));
      if (master_write) begin
        if (!prev_mw) begin
          bursts++;
          if (bursts == 1 && init_ready) chk($sformatf("v%0d latency", idx), 32'(cyc), 32'd2);
        end
        if (bidx < 4) begin
          chk($sformatf("v%0d addr c%0d", idx, cyc), master_address, v.ad[bidx]);
          chk($sformatf("v%0d burstcount c%0d", idx, cyc), 32'(master_burstcount), 32'(v.bc[bidx]));
        end
        if (q.size() > 0) begin
          chk($sformatf("v%0d data c%0d", idx, cyc), master_writedata, q[0]);
        end else begin
          checks++; errors++;
          $display("FAIL v%0d underrun c%0d: write with model queue empty", idx, cyc);
        end
      end
      prev_mw = master_write;
      if (prev_final && rem == 0) finished = 1;
      if (finished) begin
        master_waitrequest = 1'b0;
        user_write = 1'b0;
      end else begin
        master_waitrequest = v.stall ? 1'($urandom_range(0, 1)) : 1'b0;
        acc = master_write && !master_waitrequest;
        prev_busy = (rem > 0);
        prev_final = 0;
        if (acc && q.size() > 0) begin
          void'(q.pop_front());
          beats_done++;
          if (beats_done == min_b(rem)) begin
            rem -= min_b(rem);
            bidx++;
            beats_done = 0;
            prev_final = 1;
          end
        end
        gap_cnt++;
        if (feed_left > 0 && gap_cnt >= v.gap && cur_used < DEPTH) begin
          user_write = 1'b1;
          user_writedata = word_ctr;
          q.push_back(word_ctr);
          word_ctr++;
          feed_left--;
          gap_cnt = 0;
        end else begin
          user_write = 1'b0;
        end
        prev_used = cur_used;
        prev_write = exp_w;
      end
    end
    if (!finished) begin
      checks++; errors++;
      $display("FAIL v%0d timeout: command did not complete within 600 cycles", idx);
    end
    nb = bursts;
    chk($sformatf("v%0d bursts", idx), 32'(nb), 32'(v.nb));
    @(negedge clk);
    chk($sformatf("v%0d done end", idx), 32'(ctrl_done), 32'd0);
    chk($sformatf("v%0d busy end", idx), 32'(ctrl_busy), 32'd0);
    chk($sformatf("v%0d left", idx), 32'(user_used), 32'(v.left));
  endtask

  task automatic full_seq();
    preload(16);
    chk("full set", 32'(user_full), 32'd1);
    chk("full used", 32'(user_used), 32'd16);
    user_write = 1'b1;
    user_writedata = 32'hDEAD;
    @(negedge clk);
    user_write = 1'b0;
    chk("full drop used", 32'(user_used), 32'd16);
  endtask

  task automatic reset_seq();
    bit seen;
    preload(8);
    @(negedge clk);
    ctrl_baseaddress = 32'h6000; ctrl_length = 16'd8; ctrl_start = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      ctrl_start = 1'b0;
      if (master_write) seen = 1;
    end
    chk("rst burst started", 32'(master_write), 32'd1);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst async write", 32'(master_write), 32'd0);
    chk("rst async addr", master_address, 32'd0);
    chk("rst async bc", 32'(master_burstcount), 32'd0);
    chk("rst async busy", 32'(ctrl_busy), 32'd0);
    chk("rst async done", 32'(ctrl_done), 32'd0);
    chk("rst async used", 32'(user_used), 32'd0);
    chk("rst async full", 32'(user_full), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    word_ctr = 0;
    master_waitrequest = 1'b0;
    ctrl_start = 1'b0;
    ctrl_baseaddress = '0;
    ctrl_length = '0;
    user_write = 1'b0;
    user_writedata = '0;

    vecs[0] = mk(32'h1000, 8, 8, 0, 1, 1'b0, 1, 8, 0, 0, 32'h1000, 32'h0, 32'h0, 0);
    vecs[1] = mk(32'h1000, 20, 0, 20, 1, 1'b0, 3, 8, 8, 4, 32'h1000, 32'h1020, 32'h1040, 0);
    vecs[2] = mk(32'h2000, 8, 8, 0, 1, 1'b1, 1, 8, 0, 0, 32'h2000, 32'h0, 32'h0, 0);
    vecs[3] = mk(32'h0004, 4, 0, 4, 3, 1'b0, 1, 4, 0, 0, 32'h0004, 32'h0, 32'h0, 0);
    vecs[4] = mk(32'hFFFF_FFF0, 12, 12, 0, 1, 1'b0, 2, 8, 4, 0, 32'hFFFF_FFF0, 32'h0000_0010, 32'h0, 0);
    vecs[5] = mk(32'h4000, 9, 0, 0, 1, 1'b0, 2, 8, 1, 0, 32'h4000, 32'h4020, 32'h0, 7);
    vecs[6] = mk(32'h5000, 7, 0, 0, 1, 1'b0, 1, 7, 0, 0, 32'h5000, 32'h0, 32'h0, 0);
    vecs[7] = mk(32'h3000, 4, 4, 0, 1, 1'b0, 1, 4, 0, 0, 32'h3000, 32'h0, 32'h0, 0);

    repeat (2) @(negedge clk);
    chk("reset write", 32'(master_write), 32'd0);
    chk("reset addr", master_address, 32'd0);
    chk("reset bc", 32'(master_burstcount), 32'd0);
    chk("reset busy", 32'(ctrl_busy), 32'd0);
    chk("reset done", 32'(ctrl_done), 32'd0);
    chk("reset used", 32'(user_used), 32'd0);
    chk("reset full", 32'(user_full), 32'd0);
    chk("byteenable", 32'(master_byteenable), 32'hF);
    reset_n = 1'b1;

    @(negedge clk);
    ctrl_baseaddress = 32'h7000; ctrl_length = 16'd0; ctrl_start = 1'b1;
    @(negedge clk);
    ctrl_start = 1'b0;
    chk("len0 done", 32'(ctrl_done), 32'd1);
    chk("len0 busy", 32'(ctrl_busy), 32'd0);
    chk("len0 write", 32'(master_write), 32'd0);
    @(negedge clk);
    chk("len0 done once", 32'(ctrl_done), 32'd0);
    chk("len0 busy after", 32'(ctrl_busy), 32'd0);
    chk("len0 write after", 32'(master_write), 32'd0);

    for (int i = 0; i < 8; i++) begin
      if (i == 5) full_seq();
      if (i == 7) reset_seq();
      run_vec(i, vecs[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
